// File: rtl/cpu_pkg.sv
// Shared types and widths for the instruction-fetch slice.
// Provides the fetch FSM state type, datapath widths and a small helper that
// forces an address onto a 4-byte boundary.
package cpu_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_pc_register.sv
// Program-counter register for the fetch stage.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset, loads RESET_PC
//   load         update the PC this cycle
//   sel_redirect 1: next PC = word-aligned redirect_pc, 0: next PC = pc + PC_INC
//   redirect_pc  branch target
//   pc           current program counter
module pc_register
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
    parameter int                PC_INC   = 4
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              sel_redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Increment wraps modulo 2^64 by plain truncation.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            if (sel_redirect) begin
                pc_d = word_align(redirect_pc);
            end else begin
                pc_d = pc_q + ADDR_W'(PC_INC);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/DE pipeline register.
// Owns the PC, keeps at most one instruction-memory read in flight, and
// presents instruction + PC with a valid flag. Honours downstream stall and
// branch redirect; redirect wins over both stall and an arriving response.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   stall                      hold fetch outputs and PC
//   redirect, redirect_pc      flush and refetch from redirect_pc (bits [1:0] ignored)
//   imem_req, imem_addr        registered one-cycle request pulse and its address
//   imem_rvalid, imem_rdata    memory response
//   if_valid, if_inst, if_pc   fetched instruction, its address, and valid flag
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no request in flight; issue one for the current PC
// WAIT    | request in flight, response still to be consumed
// HOLD    | response captured in the skid buffer while stalled
// DISCARD | redirected while waiting; the stale response must be dropped
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
    parameter int                PC_INC   = 4
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc
);

    fetch_state_t      state_q, state_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic              if_valid_q, if_valid_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [INST_W-1:0] skid_q, skid_d;

    logic              pc_load;
    logic              pc_sel_redirect;
    logic [ADDR_W-1:0] pc;

    pc_register #(
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc_register (
        .clk          (clk),
        .reset        (reset),
        .load         (pc_load),
        .sel_redirect (pc_sel_redirect),
        .redirect_pc  (redirect_pc),
        .pc           (pc)
    );

    always_comb begin
        state_d         = state_q;
        imem_req_d      = 1'b0;
        imem_addr_d     = imem_addr_q;
        if_valid_d      = if_valid_q;
        if_inst_d       = if_inst_q;
        if_pc_d         = if_pc_q;
        skid_d          = skid_q;
        pc_load         = 1'b0;
        pc_sel_redirect = 1'b0;

        // Unstalled cycles present a bubble unless something is delivered below.
        if (!stall) begin
            if_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                // A redirect here just retargets the PC; the request goes out next cycle.
                if (redirect) begin
                    pc_load         = 1'b1;
                    pc_sel_redirect = 1'b1;
                end else begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_load         = 1'b1;
                    pc_sel_redirect = 1'b1;
                    state_d         = imem_rvalid ? IDLE : DISCARD;
                end else if (imem_rvalid) begin
                    if (stall) begin
                        skid_d  = imem_rdata;
                        state_d = HOLD;
                    end else begin
                        if_inst_d  = imem_rdata;
                        if_pc_d    = pc;
                        if_valid_d = 1'b1;
                        pc_load    = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_load         = 1'b1;
                    pc_sel_redirect = 1'b1;
                    state_d         = IDLE;
                end else if (!stall) begin
                    if_inst_d  = skid_q;
                    if_pc_d    = pc;
                    if_valid_d = 1'b1;
                    pc_load    = 1'b1;
                    state_d    = IDLE;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_load         = 1'b1;
                    pc_sel_redirect = 1'b1;
                end
                // The stale response is consumed even if a new redirect lands with it.
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect) begin
            if_valid_d = 1'b0;
            skid_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_inst_q   <= '0;
            if_pc_q     <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            if_valid_q  <= if_valid_d;
            if_inst_q   <= if_inst_d;
            if_pc_q     <= if_pc_d;
            skid_q      <= skid_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign if_valid  = if_valid_q;
    assign if_inst   = if_inst_q;
    assign if_pc     = if_pc_q;

endmodule
